// File: rtl/mux_arbiter_if.sv
// Requester/mux-side signal bundle for mux_arbiter.
// The arbiter uses the slave modport; requesters and the bench use the master modport.
interface mux_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        s;
  logic        notoe;
  logic        busy;
  logic [15:0] sw_count;

  modport master (output req, input gnt, s, notoe, busy, sw_count);
  modport slave  (input req, output gnt, s, notoe, busy, sw_count);
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin break-before-make sequencer for a shared 1-of-2 FET mux (s / ~OE pins).
// Optional pin-toggle counter is built only when MUX_ARB_SWCOUNT_EN is defined.
//
// state   | meaning
// IDLE    | mux disabled, s holds last value, arbitrating requests
// SELECT  | s driven to chosen channel, output still disabled
// ENABLE  | output enabled, waiting T_EN cycles for it to settle
// GRANT   | channel connected and granted, hold timer guards the waiting side
// RELEASE | output disabled, waiting T_DIS cycles before next select
module mux_arbiter #(
  parameter int T_EN     = 2,
  parameter int T_DIS    = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           reset,
  mux_arbiter_if.slave   bus
);

  localparam int MAXV_A = (T_EN > T_DIS) ? T_EN : T_DIS;
  localparam int MAXV   = (MAXV_A > MAX_HOLD) ? MAXV_A : MAX_HOLD;
  localparam int CW     = $clog2(MAXV + 1);

  localparam logic [CW-1:0] EN_LD   = CW'(T_EN - 1);
  localparam logic [CW-1:0] DIS_LD  = CW'(T_DIS - 1);
  localparam logic [CW-1:0] HOLD_LD = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ENABLE,
    GRANT,
    RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ch_q, ch_d;
  logic          rr_q, rr_d;
  logic          s_q, s_d;
  logic          notoe_q, notoe_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          busy_q;
  logic          own_req, other_req, preempt;

  always_comb begin
    own_req   = bus.req[ch_q];
    other_req = bus.req[~ch_q];
    preempt   = (MAX_HOLD != 0) && other_req && (cnt_q == '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          ch_d    = (bus.req == 2'b11) ? rr_q : bus.req[1];
          s_d     = ch_d;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (!own_req) begin
          state_d = RELEASE;
          cnt_d   = DIS_LD;
        end else begin
          state_d = ENABLE;
          cnt_d   = EN_LD;
        end
      end
      ENABLE: begin
        if (!own_req) begin
          state_d = RELEASE;
          cnt_d   = DIS_LD;
        end else if (cnt_q == '0) begin
          state_d = GRANT;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GRANT: begin
        if (!own_req || preempt) begin
          state_d = RELEASE;
          cnt_d   = DIS_LD;
          rr_d    = ~ch_q;
        end else if (other_req && (MAX_HOLD != 0)) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = HOLD_LD;
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pins are registered from the next state so they change on the same edge as the FSM.
    notoe_d = !((state_d == ENABLE) || (state_d == GRANT));
    gnt_d   = (state_d == GRANT) ? (ch_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= 1'b0;
      rr_q    <= 1'b0;
      s_q     <= 1'b0;
      notoe_q <= 1'b1;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      s_q     <= s_d;
      notoe_q <= notoe_d;
      gnt_q   <= gnt_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s     = s_q;
  assign bus.notoe = notoe_q;
  assign bus.busy  = busy_q;

`ifdef MUX_ARB_SWCOUNT_EN
  logic [15:0] sw_q;
  logic [1:0]  tog;

  always_comb begin
    tog = {1'b0, s_d ^ s_q} + {1'b0, notoe_d ^ notoe_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_q <= '0;
    end else if (sw_q > (16'hFFFF - {14'd0, tog})) begin
      sw_q <= 16'hFFFF;
    end else begin
      sw_q <= sw_q + {14'd0, tog};
    end
  end

  assign bus.sw_count = sw_q;
`else
  assign bus.sw_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter with T_EN=2, T_DIS=2, MAX_HOLD=16.
// Edge e0 is the first rising edge that samples a newly driven request.
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic reset;
  mux_arbiter_if bus ();

  mux_arbiter #(.T_EN(2), .T_DIS(2), .MAX_HOLD(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int inv_viol = 0;
  int e = 0;
  bit mon_en = 1'b0;
  logic prev_s, prev_notoe;

  // gnt only with the mux enabled; s may only move while notoe is high on both sides.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((bus.gnt !== 2'b00) && (bus.notoe !== 1'b0)) inv_viol++;
      if ((bus.s !== prev_s) && ((bus.notoe !== 1'b1) || (prev_notoe !== 1'b1))) inv_viol++;
    end
    prev_s     = bus.s;
    prev_notoe = bus.notoe;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (e < target) begin
      tick(1);
      e++;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if ({bus.gnt, bus.notoe, bus.s, bus.busy} !== 5'b00100) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got gnt=%b notoe=%b s=%b busy=%b, want gnt=00 notoe=1 s=0 busy=0",
                 i, bus.gnt, bus.notoe, bus.s, bus.busy);
      end
    end
    checks++;
    if (bus.sw_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_swcount: got %0d want 0", bus.sw_count);
    end
    bus.req = 2'b00;
    reset   = 1'b0;
    tick(2);
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    bus.req = 2'b01;
    e = -1;
    tick_to(0);
    checks++;
    if ({bus.s, bus.notoe, bus.gnt} !== 4'b0100) begin
      errors++;
      $display("FAIL single_e0: got s=%b notoe=%b gnt=%b want s=0 notoe=1 gnt=00", bus.s, bus.notoe, bus.gnt);
    end
    tick_to(1);
    checks++;
    if ({bus.notoe, bus.gnt, bus.busy} !== 4'b0001) begin
      errors++;
      $display("FAIL single_e1: got notoe=%b gnt=%b busy=%b want notoe=0 gnt=00 busy=1", bus.notoe, bus.gnt, bus.busy);
    end
    tick_to(2);
    checks++;
    if (bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL single_e2_gnt: got %b want 00", bus.gnt);
    end
    tick_to(3);
    checks++;
    if ({bus.gnt, bus.notoe} !== 3'b010) begin
      errors++;
      $display("FAIL single_e3: got gnt=%b notoe=%b want gnt=01 notoe=0", bus.gnt, bus.notoe);
    end
    tick_to(9);
    bus.req = 2'b00;
    tick_to(10);
    checks++;
    if ({bus.gnt, bus.notoe} !== 3'b001) begin
      errors++;
      $display("FAIL single_e10: got gnt=%b notoe=%b want gnt=00 notoe=1", bus.gnt, bus.notoe);
    end
    tick_to(12);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_e12: got %b want 1", bus.busy);
    end
    tick_to(13);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_e13: got %b want 0", bus.busy);
    end
    tick(2);
  endtask

  task automatic test_round_robin();
    reset   = 1'b1;
    bus.req = 2'b00;
    tick(2);
    reset   = 1'b0;
    bus.req = 2'b11;
    e = -1;
    tick_to(3);
    checks++;
    if ({bus.gnt, bus.s} !== 3'b010) begin
      errors++;
      $display("FAIL rr_first: got gnt=%b s=%b want gnt=01 s=0", bus.gnt, bus.s);
    end
    tick_to(5);
    bus.req = 2'b10;
    tick_to(6);
    checks++;
    if ({bus.gnt, bus.notoe} !== 3'b001) begin
      errors++;
      $display("FAIL rr_release0: got gnt=%b notoe=%b want gnt=00 notoe=1", bus.gnt, bus.notoe);
    end
    tick_to(9);
    checks++;
    if ({bus.s, bus.notoe} !== 2'b11) begin
      errors++;
      $display("FAIL rr_select1: got s=%b notoe=%b want s=1 notoe=1", bus.s, bus.notoe);
    end
    tick_to(12);
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++;
      $display("FAIL rr_gnt1: got %b want 10", bus.gnt);
    end
    bus.req = 2'b11;
    tick_to(27);
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++;
      $display("FAIL rr_hold1_e27: got %b want 10", bus.gnt);
    end
    tick_to(28);
    checks++;
    if (bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL rr_preempt1_e28: got %b want 00", bus.gnt);
    end
    tick_to(33);
    checks++;
    if ({bus.gnt, bus.s} !== 3'b000) begin
      errors++;
      $display("FAIL rr_gap_e33: got gnt=%b s=%b want gnt=00 s=0", bus.gnt, bus.s);
    end
    tick_to(34);
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL rr_alt01_e34: got %b want 01", bus.gnt);
    end
    tick_to(49);
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL rr_hold0_e49: got %b want 01", bus.gnt);
    end
    tick_to(50);
    checks++;
    if (bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL rr_preempt0_e50: got %b want 00", bus.gnt);
    end
    tick_to(56);
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++;
      $display("FAIL rr_alt10_e56: got %b want 10", bus.gnt);
    end
    bus.req = 2'b00;
    tick(8);
  endtask

  task automatic test_preempt();
    int bad;
    bus.req = 2'b01;
    e = -1;
    tick_to(3);
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL pre_gnt0: got %b want 01", bus.gnt);
    end
    tick_to(5);
    bus.req = 2'b11;
    tick_to(20);
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL pre_hold_e20: got %b want 01", bus.gnt);
    end
    tick_to(21);
    checks++;
    if (bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL pre_fall_e21: got %b want 00", bus.gnt);
    end
    tick_to(26);
    checks++;
    if (bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL pre_gap_e26: got %b want 00", bus.gnt);
    end
    tick_to(27);
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++;
      $display("FAIL pre_gnt1_e27: got %b want 10", bus.gnt);
    end
    bus.req = 2'b00;
    tick(8);
    bus.req = 2'b01;
    e = -1;
    tick_to(3);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.gnt !== 2'b01) bad++;
      tick(1);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL pre_single_hold: got %0d cycles without gnt=01, want 0", bad);
    end
    bus.req = 2'b00;
    tick(8);
  endtask

  task automatic test_reset_mid();
    bus.req = 2'b01;
    e = -1;
    tick_to(1);
    reset = 1'b1;
    tick_to(2);
    checks++;
    if ({bus.gnt, bus.notoe, bus.s, bus.busy} !== 5'b00100) begin
      errors++;
      $display("FAIL rst_enable: got gnt=%b notoe=%b s=%b busy=%b want gnt=00 notoe=1 s=0 busy=0",
               bus.gnt, bus.notoe, bus.s, bus.busy);
    end
    reset = 1'b0;
    e = -1;
    tick_to(3);
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL rst_regrant: got %b want 01", bus.gnt);
    end
    tick_to(5);
    reset = 1'b1;
    tick_to(6);
    checks++;
    if ({bus.gnt, bus.notoe, bus.s, bus.busy} !== 5'b00100) begin
      errors++;
      $display("FAIL rst_grant: got gnt=%b notoe=%b s=%b busy=%b want gnt=00 notoe=1 s=0 busy=0",
               bus.gnt, bus.notoe, bus.s, bus.busy);
    end
    reset   = 1'b0;
    bus.req = 2'b00;
    tick_to(8);
    checks++;
    if ({bus.busy, bus.notoe} !== 2'b01) begin
      errors++;
      $display("FAIL rst_idle: got busy=%b notoe=%b want busy=0 notoe=1", bus.busy, bus.notoe);
    end
    bus.req = 2'b10;
    e = -1;
    tick_to(3);
    checks++;
    if ({bus.gnt, bus.s} !== 3'b101) begin
      errors++;
      $display("FAIL rst_after_idle: got gnt=%b s=%b want gnt=10 s=1", bus.gnt, bus.s);
    end
    bus.req = 2'b00;
    tick(8);
  endtask

  task automatic test_swcount();
    logic [15:0] exp_a, exp_b, exp_c, exp_d;
`ifdef MUX_ARB_SWCOUNT_EN
    exp_a = 16'd2; exp_b = 16'd3; exp_c = 16'd6; exp_d = 16'd7;
`else
    exp_a = 16'd0; exp_b = 16'd0; exp_c = 16'd0; exp_d = 16'd0;
`endif
    reset   = 1'b1;
    bus.req = 2'b00;
    tick(2);
    reset = 1'b0;
    tick(1);
    checks++;
    if (bus.sw_count !== 16'h0) begin
      errors++;
      $display("FAIL sw_reset: got %0d want 0", bus.sw_count);
    end
    bus.req = 2'b01;
    e = -1;
    tick_to(9);
    bus.req = 2'b00;
    tick_to(16);
    checks++;
    if (bus.sw_count !== exp_a) begin
      errors++;
      $display("FAIL sw_cycle01: got %0d want %0d", bus.sw_count, exp_a);
    end
    bus.req = 2'b01;
    e = -1;
    tick_to(3);
    checks++;
    if ((bus.gnt !== 2'b01) || (bus.sw_count !== exp_b)) begin
      errors++;
      $display("FAIL sw_gnt0: got gnt=%b sw=%0d want gnt=01 sw=%0d", bus.gnt, bus.sw_count, exp_b);
    end
    bus.req = 2'b10;
    tick_to(10);
    checks++;
    if ((bus.gnt !== 2'b10) || (bus.sw_count !== exp_c)) begin
      errors++;
      $display("FAIL sw_handover: got gnt=%b sw=%0d want gnt=10 sw=%0d", bus.gnt, bus.sw_count, exp_c);
    end
    bus.req = 2'b00;
    tick(8);
    checks++;
    if (bus.sw_count !== exp_d) begin
      errors++;
      $display("FAIL sw_final: got %0d want %0d", bus.sw_count, exp_d);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_viol !== 0) begin
      errors++;
      $display("FAIL invariants: got %0d violations want 0", inv_viol);
    end
  endtask

  initial begin
    reset   = 1'b1;
    bus.req = 2'b00;
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_reset_mid();
    test_swcount();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
